unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one synchronous unified memory port between the CPU instruction-fetch requester and the load/store requester. It replaces the separate boot ROM and data memory with a single memory.
- One transaction is outstanding at a time.
- Data accesses have priority; a streak limiter guarantees fetch forward progress.
- Sits between the Cpu fetch/LSU interfaces and the memory unit.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LATENCY, 1, cycles from first memory-request cycle to valid mem_rdata (>=1)
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is waiting before the fetch is forced through

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request; held with d_* until d_gnt
d_addr  in  ADDR_W  data address
d_we  in  1  1 = store, 0 = load
d_width  in  2  00 byte, 01 half, 10 word (11 reserved, passed through)
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
d_rdata  out  DATA_W  load data (0 on store completion)
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write strobe
mem_width  out  2  access width to memory
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE and ACCESS. Owner register: FETCH or DATA. Latency counter lat_cnt.
- IDLE arbitration (combinational gnt):
  - only d_req -> d_gnt=1
  - only if_req -> if_gnt=1
  - both, with streak < MAX_DATA_STREAK -> d_gnt=1
  - both, with streak == MAX_DATA_STREAK -> if_gnt=1
  - if_gnt and d_gnt are never high together.
  - gnt is never asserted outside IDLE.
- On accept (req && gnt in IDLE), at the clock edge:
  - latch addr/we/width/wdata into request registers; fetch forces we=0, width=10.
  - set owner; go to ACCESS; lat_cnt = 0.
- Streak counter:
  - a data grant while if_req=1 increments it, saturating at MAX_DATA_STREAK.
  - any fetch grant clears it.
  - a data grant with if_req=0 clears it.
- mem_addr, mem_width and mem_wdata are driven from the request registers. They hold stable throughout ACCESS and are 0 in IDLE.
- mem_we is high only in the first ACCESS cycle (lat_cnt==0) when the latched we=1.
- In ACCESS, lat_cnt increments each cycle. When lat_cnt == MAX(MEM_LATENCY-1, 0):
  - capture mem_rdata into the owner's rdata register and pulse the owner's rvalid for one cycle (registered, so rvalid appears the cycle after capture).
  - go to IDLE.
  - for stores, d_rdata = 0.
- Latency: with MEM_LATENCY=1, request accepted at edge N, memory addressed during cycle N+1, rvalid high during cycle N+2. Earliest next grant is in cycle N+2 (IDLE), so throughput is one access per 2 cycles.
- rdata outputs hold their last value until the next rvalid. Only the owner's rdata register changes.
- Requests arriving during ACCESS wait; the requester holds them.
- Reset, including mid-ACCESS:
  - state=IDLE, owner=FETCH, lat_cnt=0, streak=0.
  - all outputs 0.
  - the in-flight transaction is dropped with no rvalid. A store already strobed stays written.

Decomposition:
- Shared package holds:
  - width encodings WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10.
  - state encoding (IDLE, ACCESS) and owner encoding (FETCH, DATA).
- One sub-module, mem_arb_pick: combinational picker with inputs if_req, d_req, streak_full and outputs pick_if, pick_d.
- Everything else (FSM, registers, counters) lives in unified_mem_arbiter.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, mem returns 0x00000013 -> if_gnt in cycle 0, mem_addr=0x100 in cycle 1, if_rvalid=1 with if_rdata=0x13 in cycle 2, d_rvalid stays 0.
- Store then load: d_we=1, d_addr=0x2000, d_width=10, d_wdata=0xDEADBEEF -> mem_we high exactly one cycle and d_rvalid with d_rdata=0. Then a load from 0x2000 -> d_rdata=0xDEADBEEF.
- Contention, streak: if_req and d_req held high continuously -> grant order D,D,D,D,F,D,D,D,D,F. if_gnt and d_gnt are never both 1.
- Width passthrough: load with d_width=00, addr=0x2003 -> mem_width=00, mem_addr=0x2003 stable across the whole ACCESS.
- MEM_LATENCY=3: fetch accepted at edge N -> rvalid in cycle N+4. A d_req raised in cycle N+1 is granted only in cycle N+4.
- Reset mid-ACCESS: rst=1 in cycle 1 of a load -> all outputs 0 next cycle, no d_rvalid ever for that load, streak=0, and a new fetch is granted on the first cycle after rst falls.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified memory arbiter: access widths, FSM state, owner.
package unified_mem_arbiter_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/unified_mem_arbiter_pick.sv
// Combinational requester picker: data wins unless the data streak is full.
module mem_arb_pick (
  input  logic if_req,
  input  logic d_req,
  input  logic streak_full,
  output logic pick_if,
  output logic pick_d
);

  assign pick_if = if_req & (~d_req | streak_full);
  assign pick_d  = d_req & ~pick_if;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store,
// one transaction outstanding, with a data-streak limiter for fetch progress.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [1:0]        d_width,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_width,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAST  = (MEM_LATENCY > 1) ? MEM_LATENCY - 1 : 0;
  localparam int LAT_W = (LAST > 0) ? $clog2(LAST + 1) : 1;
  localparam int STK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAST);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DATA_STREAK);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        width_q, width_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;

  logic pick_if, pick_d, arb_en, in_access, done;

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .streak_full (streak_q == STK_MAX),
    .pick_if     (pick_if),
    .pick_d      (pick_d)
  );

  // Grants are suppressed while reset is held so every output reads 0 then.
  assign arb_en    = (state_q == ST_IDLE) & ~rst;
  assign if_gnt    = arb_en & pick_if;
  assign d_gnt     = arb_en & pick_d;
  assign in_access = (state_q == ST_ACCESS);
  assign done      = in_access & (lat_q == LAT_LAST);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    streak_d    = streak_q;
    addr_d      = addr_q;
    we_d        = we_q;
    width_d     = width_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_gnt) begin
          addr_d   = if_addr;
          we_d     = 1'b0;
          width_d  = WIDTH_WORD;
          wdata_d  = '0;
          owner_d  = OWN_FETCH;
          state_d  = ST_ACCESS;
          lat_d    = '0;
          streak_d = '0;
        end else if (d_gnt) begin
          addr_d   = d_addr;
          we_d     = d_we;
          width_d  = d_width;
          wdata_d  = d_wdata;
          owner_d  = OWN_DATA;
          state_d  = ST_ACCESS;
          lat_d    = '0;
          // Only a waiting fetch makes a data grant count toward the streak.
          if (!if_req)                streak_d = '0;
          else if (streak_q != STK_MAX) streak_d = streak_q + 1'b1;
        end
      end
      ST_ACCESS: begin
        lat_d = lat_q + 1'b1;
        if (done) begin
          state_d = ST_IDLE;
          lat_d   = '0;
          if (owner_q == OWN_DATA) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = we_q ? '0 : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_FETCH;
      lat_q       <= '0;
      streak_q    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      width_q     <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      streak_q    <= streak_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      width_q     <= width_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

  // Memory side shows the latched request only while a transaction is in flight.
  assign mem_addr  = in_access ? addr_q  : '0;
  assign mem_width = in_access ? width_q : '0;
  assign mem_wdata = in_access ? wdata_q : '0;
  assign mem_we    = in_access & (lat_q == '0) & we_q;

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Random + directed bench for unified_mem_arbiter with a transaction-level reference model.
module tb_unified_mem_arbiter;

  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [1:0]  d_width = 0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_width;

  logic        l_if_req = 0, l_d_req = 0, l_d_we = 0;
  logic [31:0] l_if_addr = 0, l_d_addr = 0, l_d_wdata = 0, l_mem_rdata = 0;
  logic [1:0]  l_d_width = 0;
  logic        l_if_gnt, l_if_rvalid, l_d_gnt, l_d_rvalid, l_mem_we;
  logic [31:0] l_if_rdata, l_d_rdata, l_mem_addr, l_mem_wdata;
  logic [1:0]  l_mem_width;

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_DATA_STREAK(MAXS)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_width(d_width), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_width(mem_width), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .MAX_DATA_STREAK(MAXS)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(l_if_req), .if_addr(l_if_addr), .if_gnt(l_if_gnt), .if_rvalid(l_if_rvalid), .if_rdata(l_if_rdata),
    .d_req(l_d_req), .d_addr(l_d_addr), .d_we(l_d_we), .d_width(l_d_width), .d_wdata(l_d_wdata),
    .d_gnt(l_d_gnt), .d_rvalid(l_d_rvalid), .d_rdata(l_d_rdata),
    .mem_addr(l_mem_addr), .mem_we(l_mem_we), .mem_width(l_mem_width), .mem_wdata(l_mem_wdata),
    .mem_rdata(l_mem_rdata));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one outstanding transaction, a countdown of memory cycles,
  // and the priority rule applied to the requests seen in each cycle.
  bit          mon_en = 0;
  int          m_left = 0, m_streak = 0;
  bit          m_own_d = 0, m_we = 0, m_first = 0, m_if_rv = 0, m_d_rv = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;
  logic [1:0]  m_width = 0;
  bit          m_idle, e_if_gnt, e_d_gnt, s_rst, s_if_req, s_d_req, s_d_we, s_mem_we;
  logic [31:0] s_if_addr, s_d_addr, s_d_wdata, s_mem_addr, s_mem_wdata;
  logic [1:0]  s_d_width;

  initial begin
    forever begin
      @(negedge clk);
      s_rst = rst; s_if_req = if_req; s_if_addr = if_addr; s_d_req = d_req;
      s_d_addr = d_addr; s_d_we = d_we; s_d_width = d_width; s_d_wdata = d_wdata;
      s_mem_we = mem_we; s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
      m_idle   = (m_left == 0);
      e_if_gnt = !s_rst && m_idle && s_if_req && (!s_d_req || m_streak == MAXS);
      e_d_gnt  = !s_rst && m_idle && s_d_req && !e_if_gnt;
      if (mon_en) begin
        chk("gnt", {if_gnt, d_gnt}, {e_if_gnt, e_d_gnt});
        chk("rvalid", {if_rvalid, d_rvalid}, {m_if_rv, m_d_rv});
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        chk("mem_addr", mem_addr, m_idle ? 32'h0 : m_addr);
        chk("mem_ctl", {mem_we, mem_width}, m_idle ? 3'b000 : {m_first && m_we, m_width});
        if (mem_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      @(posedge clk);
      if (s_mem_we) mem[s_mem_addr[9:2]] = s_mem_wdata;
      m_if_rv = 0;
      m_d_rv  = 0;
      if (s_rst) begin
        m_left = 0; m_streak = 0; m_first = 0; m_if_rdata = 0; m_d_rdata = 0;
      end else if (!m_idle) begin
        if (m_left == 1) begin
          if (m_own_d) begin
            m_d_rv = 1;
            m_d_rdata = m_we ? 32'h0 : mem[m_addr[9:2]];
          end else begin
            m_if_rv = 1;
            m_if_rdata = mem[m_addr[9:2]];
          end
        end
        m_left--;
        m_first = 0;
      end else if (e_if_gnt) begin
        m_own_d = 0; m_addr = s_if_addr; m_we = 0; m_width = 2'b10; m_wdata = 0;
        m_left = 1; m_first = 1; m_streak = 0;
      end else if (e_d_gnt) begin
        m_own_d = 1; m_addr = s_d_addr; m_we = s_d_we; m_width = s_d_width; m_wdata = s_d_wdata;
        m_left = 1; m_first = 1;
        m_streak = s_if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end
    end
  end

  logic [9:0] seq;
  int         ngnt, nboth;
  bit         gi, gd;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[64] = 32'h0000_0013;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_out", |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                     mem_addr, mem_we, mem_width, mem_wdata}, 1'b0);
    step();
    rst = 0;
    mon_en = 1;
    step();

    // Fetch only
    if_req = 1; if_addr = 32'h100;
    @(negedge clk); chk("f_gnt", if_gnt, 1'b1);
    step(); if_req = 0;
    @(negedge clk); chk("f_maddr", mem_addr, 32'h100); chk("f_rv1", if_rvalid, 1'b0);
    step();
    @(negedge clk); chk("f_rv2", if_rvalid, 1'b1); chk("f_rdata", if_rdata, 32'h13);
    chk("f_drv", d_rvalid, 1'b0);

    // Store then load
    step(); d_req = 1; d_we = 1; d_addr = 32'h2000; d_width = 2'b10; d_wdata = 32'hDEADBEEF;
    @(negedge clk); chk("st_gnt", d_gnt, 1'b1);
    step(); d_req = 0;
    @(negedge clk); chk("st_we1", mem_we, 1'b1);
    step();
    @(negedge clk); chk("st_we2", mem_we, 1'b0); chk("st_rv", d_rvalid, 1'b1); chk("st_rdata", d_rdata, 32'h0);
    step(); d_req = 1; d_we = 0;
    @(negedge clk); chk("ld_gnt", d_gnt, 1'b1);
    step(); d_req = 0;
    step();
    @(negedge clk); chk("ld_rv", d_rvalid, 1'b1); chk("ld_rdata", d_rdata, 32'hDEADBEEF);

    // Width passthrough
    step(); d_req = 1; d_we = 0; d_width = 2'b00; d_addr = 32'h2003;
    @(negedge clk); chk("w_gnt", d_gnt, 1'b1);
    step(); d_req = 0;
    @(negedge clk); chk("w_width", mem_width, 2'b00); chk("w_addr", mem_addr, 32'h2003);
    step();
    @(negedge clk); chk("w_idle_addr", mem_addr, 32'h0);

    // Contention: both held high
    step(); if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_width = 2'b10; d_addr = 32'h80;
    seq = '0; ngnt = 0; nboth = 0;
    for (int c = 0; c < 40 && ngnt < 10; c++) begin
      @(negedge clk);
      if (if_gnt && d_gnt) nboth++;
      if (if_gnt || d_gnt) begin seq = {seq[8:0], d_gnt}; ngnt++; end
      step();
    end
    chk("ct_ngnt", ngnt, 10);
    chk("ct_order", seq, 10'b11110_11110);
    chk("ct_both", nboth, 0);
    if_req = 0; d_req = 0;
    repeat (3) step();

    // Reset in the middle of a load
    d_req = 1; d_we = 0; d_addr = 32'h40;
    @(negedge clk); chk("rm_gnt", d_gnt, 1'b1);
    step(); d_req = 0; rst = 1;
    step(); if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    chk("rm_out", |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                    mem_addr, mem_we, mem_width, mem_wdata}, 1'b0);
    step(); rst = 0;
    @(negedge clk); chk("rm_fgnt", if_gnt, 1'b1); chk("rm_drv0", d_rvalid, 1'b0);
    step(); if_req = 0;
    repeat (3) begin @(negedge clk); chk("rm_drv", d_rvalid, 1'b0); step(); end

    // MEM_LATENCY=3: memory data only valid in the last access cycle
    l_if_req = 1; l_if_addr = 32'h100;
    @(negedge clk); chk("l3_fgnt", l_if_gnt, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(); l_if_req = 0; l_d_req = 1; l_d_addr = 32'h44;
      l_mem_rdata = (k == 3) ? 32'h13 : 32'hBADBAD00;
      @(negedge clk);
      chk("l3_dgnt", l_d_gnt, k == 4);
      chk("l3_ifrv", l_if_rvalid, k == 4);
      if (k < 4) chk("l3_maddr", l_mem_addr, 32'h100);
    end
    chk("l3_rdata", l_if_rdata, 32'h13);
    step(); l_d_req = 0;
    repeat (5) step();

    // Randomized traffic with occasional resets; the model checks every cycle
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); gi = if_gnt; gd = d_gnt;
      step();
      rst = ($urandom_range(0, 79) == 0);
      if (gi || !if_req) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = $urandom & 32'h3fc;
      end
      if (gd || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_addr = $urandom & 32'h3ff;
        d_we = $urandom_range(0, 1);
        d_width = 2'($urandom_range(0, 3));
        d_wdata = $urandom;
      end
    end
    rst = 0; if_req = 0; d_req = 0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
